decode_unit: RTL
================

# decode_unit

Second pipeline stage. Consumes the fetch stage's valid/ready instruction stream (instruction, PC, predicted-taken flag) and decodes RV32I into a registered micro-op bundle for execute. Returns same-cycle control-flow hints (JAL target, branch target) to fetch. Provides a one-entry skid buffer so `ready_o` is registered, and drops all held work on a mispredict flush from execute.

## Interface
- `ADDR_W`, 32, PC/target width.
- `clk`  in  1  clock; one clock domain.
- `rst_n`  in  1  synchronous active-low reset.
- `valid_i`  in  1  fetch has an instruction.
- `inst_i`  in  32  instruction word.
- `pc_i`  in  ADDR_W  PC of `inst_i`.
- `pred_taken_i`  in  1  fetch's predicted direction for a branch.
- `ready_o`  out  1  decode can accept; registered.
- `jmp_o`  out  1  unconditional redirect to fetch.
- `branch_o`  out  1  input is a conditional branch.
- `jmp_target_o`  out  ADDR_W  redirect/branch target.
- `jalr_valid_i`  in  1  execute resolved a JALR this cycle.
- `jalr_target_i`  in  ADDR_W  resolved JALR target.
- `flush_i`  in  1  mispredict; discard all held/incoming work.
- `ready_i`  in  1  execute accepts.
- `valid_o`  out  1  bundle valid.
- `cls_o`  out  4  `inst_cls_e` class.
- `rd_o`, `rs1_o`, `rs2_o`  out  5 each  register indices.
- `funct3_o`  out  3; `funct7b5_o`  out  1  (inst[30]).
- `imm_o`  out  32  sign-extended immediate.
- `pc_o`  out  ADDR_W; `pred_taken_o`  out  1; `illegal_o`  out  1.

## Operation
- Input transfer: `valid_i & ready_o`. Output transfer: `valid_o & ready_i`.
- Decode is combinational on the input. The decoded bundle is what gets stored. Output and skid registers hold decoded bundles.
- Classes: ALU_R, ALU_I, LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC, SYSTEM, FENCE, ILLEGAL.
- ILLEGAL covers an unknown opcode or `inst_i[1:0]!=2'b11`. For ILLEGAL: `illegal_o=1`, rd=0, imm=0.
- Immediates are I/S/B/U/J format, sign-extended from inst[31]. For R-type and ILLEGAL, imm=0.
- Hints are combinational and level-qualified by `valid_i`. They do not depend on `ready_o` or `flush_i`:
  - JAL: `jmp_o=1`, `jmp_target_o = pc_i + immJ`.
  - BRANCH: `branch_o=1`, `jmp_target_o = pc_i + immB`.
  - `jalr_valid_i`: `jmp_o=1`, `jmp_target_o = jalr_target_i`. This has priority over input-derived hints.
  - Otherwise `jmp_o=0`, `branch_o=0`, target=0.
- All target additions are modulo 2^ADDR_W; wrap-around is silently allowed.
- State machine (`skid_valid`, `valid_o`):
  - EMPTY: on input transfer, go to HOLD and load the output register.
  - HOLD:
    - Input transfer and output transfer: stay in HOLD; the output register takes the new bundle.
    - Input transfer without output transfer: go to FULL; the new bundle goes to skid.
    - Output transfer only: go to EMPTY.
  - FULL (`ready_o=0`): on output transfer, go to HOLD; skid moves to the output register.
- `ready_o = !skid_valid`, registered.
- `flush_i`: next state is EMPTY. Skid and output valids clear, and any input transfer that cycle is dropped. Flush has priority over every other event.
- Reset: `valid_o=0`, `ready_o=1`, and every bundle output is 0. Reset applies mid-operation too, discarding all held entries.

## Timing
- Latency is 1 cycle: an input accepted at edge N appears on `valid_o` after edge N.
- Sustained throughput is 1/cycle while `ready_i=1`.
- Stall: `ready_o` falls the cycle after the first unaccepted input when HOLD moves to FULL. Exactly one extra instruction is absorbed.
- While `valid_o=1 & !ready_i`, bundle outputs stay stable.
- Hints change in the same cycle as `inst_i`/`pc_i`/`jalr_*`; there are no registers on them.
- `flush_i` with `ready_i`: the current output is not transferred (flush wins).

## Structure
- The `typedefs` package gains `inst_cls_e` (4-bit enum of the classes above) and `imm_fmt_e` (I, S, B, U, J, NONE). The existing `OPC_*` opcode constants are reused.
- Sub-module `imm_gen_sbm` (combinational) takes inst and `imm_fmt_e` and returns a 32-bit immediate. It is used once for the bundle.
- Hint target adders live inline in `decode_unit`.

## Test plan
- ADDI `0x00500093` at pc 0x0, `ready_i=1` -> next cycle `valid_o=1`, cls=ALU_I, rd=1, rs1=0, imm=5, pc_o=0.
- JAL `0x008000EF` at pc 0x100 -> same cycle `jmp_o=1`, `jmp_target_o=0x108`. Next cycle cls=JAL, rd=1, imm=8.
- BEQ `0xFE000EE3` at pc 0x20, `pred_taken_i=1` -> `branch_o=1`, `jmp_target_o=0x1C`. Bundle imm=0xFFFFFFFC, pred_taken_o=1.
- Backpressure:
  - Stimulus: 3 back-to-back inputs, `ready_i=0` for 3 cycles.
  - Expected: `ready_o` drops after the 2nd is accepted; the 3rd is held by fetch. Releasing `ready_i` outputs the three in order with no loss or duplication.
- FULL state plus `flush_i` pulse -> next cycle `valid_o=0`, `ready_o=1`. A `valid_i` input in the flush cycle does not appear.
- `0xFFFFFFFF`, then `jalr_valid_i=1` with target 0x40 alongside a JAL input -> `illegal_o=1`, cls=ILLEGAL. `jmp_target_o=0x40` (JALR priority).

Source files
------------

// File: rtl/decode_unit_pkg.sv
// Shared types for the decode stage: RV32I opcodes, instruction classes,
// immediate formats and the skid-buffer state encoding.
package decode_unit_pkg;

  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  typedef enum logic [3:0] {
    CLS_ALU_R   = 4'd0,
    CLS_ALU_I   = 4'd1,
    CLS_LOAD    = 4'd2,
    CLS_STORE   = 4'd3,
    CLS_BRANCH  = 4'd4,
    CLS_JAL     = 4'd5,
    CLS_JALR    = 4'd6,
    CLS_LUI     = 4'd7,
    CLS_AUIPC   = 4'd8,
    CLS_SYSTEM  = 4'd9,
    CLS_FENCE   = 4'd10,
    CLS_ILLEGAL = 4'd11
  } inst_cls_e;

  typedef enum logic [2:0] {
    IMM_I    = 3'd0,
    IMM_S    = 3'd1,
    IMM_B    = 3'd2,
    IMM_U    = 3'd3,
    IMM_J    = 3'd4,
    IMM_NONE = 3'd5
  } imm_fmt_e;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_HOLD  = 2'd1,
    ST_FULL  = 2'd2
  } dec_state_e;

  // The full 7-bit opcode is matched, so inst[1:0] != 2'b11 falls to ILLEGAL.
  function automatic inst_cls_e opc_to_cls(input logic [6:0] opc);
    inst_cls_e cls;
    case (opc)
      OPC_OP:       cls = CLS_ALU_R;
      OPC_OP_IMM:   cls = CLS_ALU_I;
      OPC_LOAD:     cls = CLS_LOAD;
      OPC_STORE:    cls = CLS_STORE;
      OPC_BRANCH:   cls = CLS_BRANCH;
      OPC_JAL:      cls = CLS_JAL;
      OPC_JALR:     cls = CLS_JALR;
      OPC_LUI:      cls = CLS_LUI;
      OPC_AUIPC:    cls = CLS_AUIPC;
      OPC_SYSTEM:   cls = CLS_SYSTEM;
      OPC_MISC_MEM: cls = CLS_FENCE;
      default:      cls = CLS_ILLEGAL;
    endcase
    return cls;
  endfunction

  function automatic imm_fmt_e cls_to_fmt(input inst_cls_e cls);
    imm_fmt_e fmt;
    case (cls)
      CLS_ALU_I, CLS_LOAD, CLS_JALR,
      CLS_SYSTEM, CLS_FENCE:        fmt = IMM_I;
      CLS_STORE:                    fmt = IMM_S;
      CLS_BRANCH:                   fmt = IMM_B;
      CLS_LUI, CLS_AUIPC:           fmt = IMM_U;
      CLS_JAL:                      fmt = IMM_J;
      default:                      fmt = IMM_NONE;
    endcase
    return fmt;
  endfunction

endpackage

// File: rtl/decode_unit_if.sv
// Fetch/decode/execute signal bundle for the decode stage.
// slave = decode_unit's view, master = the surrounding pipeline's view.
interface decode_unit_if #(parameter int ADDR_W = 32);
  import decode_unit_pkg::*;

  // Handshake: a beat moves on a rising clk edge where valid and ready are
  // both high. A producer holding valid keeps its payload stable; ready may
  // be anything and is not allowed to depend on valid of the same channel.

  // fetch -> decode
  logic              valid_i;
  logic [31:0]       inst_i;
  logic [ADDR_W-1:0] pc_i;
  logic              pred_taken_i;
  logic              ready_o;

  // same-cycle control-flow hints back to fetch
  logic              jmp_o;
  logic              branch_o;
  logic [ADDR_W-1:0] jmp_target_o;

  // execute -> decode
  logic              jalr_valid_i;
  logic [ADDR_W-1:0] jalr_target_i;
  logic              flush_i;
  logic              ready_i;

  // decode -> execute micro-op bundle
  logic              valid_o;
  logic [3:0]        cls_o;
  logic [4:0]        rd_o;
  logic [4:0]        rs1_o;
  logic [4:0]        rs2_o;
  logic [2:0]        funct3_o;
  logic              funct7b5_o;
  logic [31:0]       imm_o;
  logic [ADDR_W-1:0] pc_o;
  logic              pred_taken_o;
  logic              illegal_o;

  // debug view of the skid-buffer state
  dec_state_e        dbg_state_o;

  modport slave (
    input  valid_i, inst_i, pc_i, pred_taken_i,
    input  jalr_valid_i, jalr_target_i, flush_i, ready_i,
    output ready_o, jmp_o, branch_o, jmp_target_o,
    output valid_o, cls_o, rd_o, rs1_o, rs2_o, funct3_o, funct7b5_o,
    output imm_o, pc_o, pred_taken_o, illegal_o, dbg_state_o
  );

  modport master (
    output valid_i, inst_i, pc_i, pred_taken_i,
    output jalr_valid_i, jalr_target_i, flush_i, ready_i,
    input  ready_o, jmp_o, branch_o, jmp_target_o,
    input  valid_o, cls_o, rd_o, rs1_o, rs2_o, funct3_o, funct7b5_o,
    input  imm_o, pc_o, pred_taken_o, illegal_o, dbg_state_o
  );

endinterface

// File: rtl/decode_unit_imm_gen.sv
// Combinational RV32I immediate generator; every format sign-extends from
// inst[31], and IMM_NONE yields zero.
module imm_gen_sbm
  import decode_unit_pkg::*;
(
  input  logic [31:0] inst_i,
  input  imm_fmt_e    fmt_i,
  output logic [31:0] imm_o
);

  always_comb begin
    imm_o = '0;
    case (fmt_i)
      IMM_I: imm_o = {{20{inst_i[31]}}, inst_i[31:20]};
      IMM_S: imm_o = {{20{inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
      IMM_B: imm_o = {{19{inst_i[31]}}, inst_i[31], inst_i[7],
                      inst_i[30:25], inst_i[11:8], 1'b0};
      IMM_U: imm_o = {inst_i[31:12], 12'h000};
      IMM_J: imm_o = {{11{inst_i[31]}}, inst_i[31], inst_i[19:12],
                      inst_i[20], inst_i[30:21], 1'b0};
      default: imm_o = '0;
    endcase
  end

endmodule

// File: rtl/decode_unit.sv
// RV32I decode stage: combinational decode into a registered micro-op bundle
// behind a one-entry skid buffer, plus unregistered control-flow hints.
module decode_unit
  import decode_unit_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input logic          clk,
  input logic          rst_n,
  decode_unit_if.slave bus
);

  typedef struct packed {
    inst_cls_e         cls;
    logic [4:0]        rd;
    logic [4:0]        rs1;
    logic [4:0]        rs2;
    logic [2:0]        funct3;
    logic              funct7b5;
    logic [31:0]       imm;
    logic [ADDR_W-1:0] pc;
    logic              pred_taken;
    logic              illegal;
  } bundle_t;

  // ---------------------------------------------------------------- decode
  inst_cls_e   dec_cls;
  imm_fmt_e    dec_fmt;
  logic [31:0] dec_imm;
  bundle_t     bundle_d;

  assign dec_cls = opc_to_cls(bus.inst_i[6:0]);
  assign dec_fmt = cls_to_fmt(dec_cls);

  imm_gen_sbm u_imm_gen (
    .inst_i (bus.inst_i),
    .fmt_i  (dec_fmt),
    .imm_o  (dec_imm)
  );

  always_comb begin
    bundle_d            = '0;
    bundle_d.cls        = dec_cls;
    bundle_d.illegal    = (dec_cls == CLS_ILLEGAL);
    bundle_d.rd         = bundle_d.illegal ? 5'd0 : bus.inst_i[11:7];
    bundle_d.rs1        = bus.inst_i[19:15];
    bundle_d.rs2        = bus.inst_i[24:20];
    bundle_d.funct3     = bus.inst_i[14:12];
    bundle_d.funct7b5   = bus.inst_i[30];
    bundle_d.imm        = dec_imm;
    bundle_d.pc         = bus.pc_i;
    bundle_d.pred_taken = bus.pred_taken_i;
  end

  // ----------------------------------------------------------------- hints
  // Separate J/B immediates so the bundle's generator stays off the
  // fetch-redirect path; sums wrap modulo 2^ADDR_W.
  logic [31:0]       hint_imm_j;
  logic [31:0]       hint_imm_b;
  logic [ADDR_W-1:0] jal_target;
  logic [ADDR_W-1:0] br_target;

  assign hint_imm_j = {{12{bus.inst_i[31]}}, bus.inst_i[19:12], bus.inst_i[20],
                       bus.inst_i[30:21], 1'b0};
  assign hint_imm_b = {{20{bus.inst_i[31]}}, bus.inst_i[7], bus.inst_i[30:25],
                       bus.inst_i[11:8], 1'b0};
  assign jal_target = bus.pc_i + ADDR_W'($signed(hint_imm_j));
  assign br_target  = bus.pc_i + ADDR_W'($signed(hint_imm_b));

  always_comb begin
    bus.jmp_o        = 1'b0;
    bus.branch_o     = 1'b0;
    bus.jmp_target_o = '0;
    if (bus.jalr_valid_i) begin
      bus.jmp_o        = 1'b1;
      bus.jmp_target_o = bus.jalr_target_i;
    end else if (bus.valid_i) begin
      if (dec_cls == CLS_JAL) begin
        bus.jmp_o        = 1'b1;
        bus.jmp_target_o = jal_target;
      end else if (dec_cls == CLS_BRANCH) begin
        bus.branch_o     = 1'b1;
        bus.jmp_target_o = br_target;
      end
    end
  end

  // ---------------------------------------------------------- skid buffer
  dec_state_e state_q;
  logic       valid_q;
  logic       ready_q;
  bundle_t    out_q;
  bundle_t    skid_q;
  logic       in_xfer;
  logic       out_xfer;

  assign in_xfer  = bus.valid_i & ready_q;
  assign out_xfer = valid_q & bus.ready_i;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_EMPTY;
      valid_q <= 1'b0;
      ready_q <= 1'b1;
      out_q   <= '0;
      skid_q  <= '0;
    end else if (bus.flush_i) begin
      // Bundle contents are left stale; only the valids matter downstream.
      state_q <= ST_EMPTY;
      valid_q <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (in_xfer) begin
            out_q   <= bundle_d;
            valid_q <= 1'b1;
            state_q <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (in_xfer && out_xfer) begin
            out_q   <= bundle_d;
          end else if (in_xfer) begin
            skid_q  <= bundle_d;
            ready_q <= 1'b0;
            state_q <= ST_FULL;
          end else if (out_xfer) begin
            valid_q <= 1'b0;
            state_q <= ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (out_xfer) begin
            out_q   <= skid_q;
            ready_q <= 1'b1;
            state_q <= ST_HOLD;
          end
        end
        default: begin
          state_q <= ST_EMPTY;
          valid_q <= 1'b0;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign bus.ready_o      = ready_q;
  assign bus.valid_o      = valid_q;
  assign bus.cls_o        = out_q.cls;
  assign bus.rd_o         = out_q.rd;
  assign bus.rs1_o        = out_q.rs1;
  assign bus.rs2_o        = out_q.rs2;
  assign bus.funct3_o     = out_q.funct3;
  assign bus.funct7b5_o   = out_q.funct7b5;
  assign bus.imm_o        = out_q.imm;
  assign bus.pc_o         = out_q.pc;
  assign bus.pred_taken_o = out_q.pred_taken;
  assign bus.illegal_o    = out_q.illegal;
  assign bus.dbg_state_o  = state_q;

endmodule
